// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - state encoding and UART register constants for the UART transmit arbiter
package uart_arb_pkg;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_CFG   = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;

  typedef enum logic [2:0] {
    S_INIT  = ST_INIT,
    S_CFG   = ST_CFG,
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_GAP   = ST_GAP,
    S_WAIT  = ST_WAIT
  } arb_state_t;

  localparam logic [3:0] DATA_ADDR = 4'd0;
  localparam logic [3:0] CTRL_ADDR = 4'd1;
  localparam logic [7:0] LF        = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or above ptr, wrapping
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            valid
);

  logic [PW:0] idx_sum;
  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the closest set bit to ptr is assigned last.
  always_comb begin
    grant   = '0;
    valid   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx_sum = {1'b0, ptr} + (PW+1)'(i);
      if (idx_sum >= (PW+1)'(NREQ)) begin
        idx_sum = idx_sum - (PW+1)'(NREQ);
      end
      idx = idx_sum[PW-1:0];
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - shares one memory-mapped UART transmitter between NREQ byte producers
// Build option UART_ARB_LINELOCK_EN holds the grant on one requester until it writes a line feed.
module uart_tx_arb #(
  parameter int         NREQ      = 3,
  parameter logic [7:0] CTRL_INIT = 8'd3,
  parameter logic [3:0] CTRL_ADDR = uart_arb_pkg::CTRL_ADDR,
  parameter logic [3:0] DATA_ADDR = uart_arb_pkg::DATA_ADDR,
  parameter int         MIN_GAP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  input  logic              tx_ready,
  output logic              u_cs,
  output logic              u_wen,
  output logic [3:0]        u_addr,
  output logic [31:0]       u_din,
  output logic              busy
);

  import uart_arb_pkg::*;

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MIN_GAP + 1);

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] pick_req;
  logic [CW-1:0]   gap_cnt;
  logic [7:0]      req_bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  assign next_ptr = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);

`ifdef UART_ARB_LINELOCK_EN
  logic locked;

  // gnt keeps the locked requester's index, so masking to that bit narrows the pick to it.
  always_comb begin
    pick_req = req;
    if (locked) begin
      pick_req = req & (NREQ'(1) << gnt);
    end
  end
`else
  assign pick_req = req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_INIT;
      u_cs    <= 1'b0;
      u_wen   <= 1'b0;
      u_addr  <= '0;
      u_din   <= '0;
      ack     <= '0;
      busy    <= 1'b1;
      rr_ptr  <= '0;
      gap_cnt <= '0;
      gnt     <= '0;
`ifdef UART_ARB_LINELOCK_EN
      locked  <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          u_cs   <= 1'b1;
          u_wen  <= 1'b1;
          u_addr <= CTRL_ADDR;
          u_din  <= {24'b0, CTRL_INIT};
          state  <= S_CFG;
        end
        S_CFG: begin
          u_cs    <= 1'b0;
          u_wen   <= 1'b0;
          gap_cnt <= CW'(MIN_GAP);
          state   <= S_GAP;
        end
        S_IDLE: begin
          if (pick_valid) begin
            gnt    <= pick_idx;
            u_cs   <= 1'b1;
            u_wen  <= 1'b1;
            u_addr <= DATA_ADDR;
            u_din  <= {24'b0, req_bytes[pick_idx]};
            ack    <= NREQ'(1) << pick_idx;
            busy   <= 1'b1;
            state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          u_cs    <= 1'b0;
          u_wen   <= 1'b0;
          ack     <= '0;
          gap_cnt <= CW'(MIN_GAP);
          state   <= S_GAP;
`ifdef UART_ARB_LINELOCK_EN
          if (u_din[7:0] == LF) begin
            rr_ptr <= next_ptr;
            locked <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
`else
          rr_ptr  <= next_ptr;
`endif
        end
        // tx_ready lags a write by a few cycles, so it is not trusted until the gap expires.
        S_GAP: begin
          gap_cnt <= gap_cnt - CW'(1);
          if (gap_cnt == CW'(1)) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed and randomized checks of uart_tx_arb against a behavioural model
module tb_uart_tx_arb;

  localparam int NREQ    = 3;
  localparam int MIN_GAP = 4;
`ifdef UART_ARB_LINELOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic              tx_ready = 1'b0;
  logic              u_cs;
  logic              u_wen;
  logic [3:0]        u_addr;
  logic [31:0]       u_din;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [NREQ-1:0] req_at_edge;
  logic [7:0] cur [NREQ];

  uart_tx_arb #(
    .NREQ      (NREQ),
    .CTRL_INIT (8'd3),
    .CTRL_ADDR (4'd1),
    .DATA_ADDR (4'd0),
    .MIN_GAP   (MIN_GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_ready (tx_ready),
    .u_cs     (u_cs),
    .u_wen    (u_wen),
    .u_addr   (u_addr),
    .u_din    (u_din),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    req_at_edge = req;
    @(negedge clk);
    cycle++;
  endtask

  task automatic pack();
    for (int k = 0; k < NREQ; k++) req_data[8*k +: 8] = cur[k];
  endtask

  task automatic wait_write(input string tag, input int maxc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (u_cs !== 1'b1 && n < maxc);
    chk({tag, "_seen"}, u_cs, 1);
  endtask

  task automatic do_reset();
    int n;
    tx_ready = 1'b1;
    req = '0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (busy !== 1'b0 && n < 40);
    chk("reinit_idle", busy, 0);
  endtask

  // Reference arbitration: locked requester only, else first pending from rr upward.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int rr, input bit lk, input int lid);
    int j;
    if (lk) return (((r >> lid) & 1) != 0) ? lid : -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (rr + k) % NREQ;
      if (((r >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  initial begin
    int n, cs_seen, g, rr_m, lid_m, last_w, nw, p0, idx;
    bit lk_m;
    logic [7:0] msg [4];
    logic [7:0] got [5];
    logic [7:0] exp_ll [5];

    for (int k = 0; k < NREQ; k++) cur[k] = 8'h00;

    // Reset state and the one-time control register write.
    cyc();
    cyc();
    chk("rst_cs", u_cs, 0);
    chk("rst_wen", u_wen, 0);
    chk("rst_addr", u_addr, 0);
    chk("rst_din", u_din, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;
    cyc();
    chk("cfg_cs", u_cs, 1);
    chk("cfg_wen", u_wen, 1);
    chk("cfg_addr", u_addr, 1);
    chk("cfg_din", u_din, 32'h3);
    cs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (u_cs) cs_seen++;
    end
    chk("cfg_quiet", cs_seen, 0);
    chk("cfg_busy_held", busy, 1);
    tx_ready = 1'b1;
    cyc();
    chk("cfg_busy_drop", busy, 0);

    // Single requester: grant latency and minimum spacing.
    cur[0] = 8'h6D;
    pack();
    req = 3'b001;
    cyc();
    chk("single_cs", u_cs, 1);
    chk("single_addr", u_addr, 0);
    chk("single_din", u_din, 32'h6D);
    chk("single_ack", ack, 3'b001);
    cur[0] = 8'h20;
    pack();
    wait_write("single2", 30, n);
    chk("single_spacing", n, MIN_GAP + 3);
    chk("single2_din", u_din, 32'h20);
    chk("single2_ack", ack, 3'b001);
    req = '0;

    // Contention: all three requesters held.
    do_reset();
    cur[0] = 8'h41;
    cur[1] = 8'h42;
    cur[2] = 8'h43;
    pack();
    req = 3'b111;
    for (int w = 0; w < 6; w++) begin
      wait_write("cont", 30, n);
      idx = LOCK ? 0 : (w % 3);
      chk("cont_din", u_din, 32'h41 + idx);
      chk("cont_ack", ack, 3'b001 << idx);
    end
    req = '0;

    // tx_ready stuck low after a write.
    do_reset();
    cur[2] = 8'h55;
    pack();
    req = 3'b100;
    wait_write("txr_first", 30, n);
    chk("txr_first_din", u_din, 32'h55);
    tx_ready = 1'b0;
    cur[2] = 8'h0A;
    pack();
    cs_seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (u_cs) cs_seen++;
    end
    chk("txr_blocked", cs_seen, 0);
    tx_ready = 1'b1;
    wait_write("txr_resume", 30, n);
    chk("txr_latency", n, 2);
    chk("txr_din", u_din, 32'h0A);
    req = '0;

    // Reset during GAP with req[1] pending.
    cur[0] = 8'h11;
    pack();
    req = 3'b001;
    wait_write("rgap_pre", 30, n);
    cur[1] = 8'h22;
    pack();
    req = 3'b010;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    chk("rgap_cfg_cs", u_cs, 1);
    chk("rgap_cfg_addr", u_addr, 1);
    chk("rgap_cfg_din", u_din, 32'h3);
    chk("rgap_cfg_ack", ack, 0);
    wait_write("rgap_serve", 40, n);
    chk("rgap_din", u_din, 32'h22);
    chk("rgap_ack", ack, 3'b010);
    req = '0;

    // Line lock: "g 1\n" from req0 against 'X' from req1.
    do_reset();
    msg = '{8'h67, 8'h20, 8'h31, 8'h0A};
    if (LOCK) exp_ll = '{8'h67, 8'h20, 8'h31, 8'h0A, 8'h58};
    else      exp_ll = '{8'h67, 8'h58, 8'h20, 8'h31, 8'h0A};
    p0 = 0;
    cur[0] = msg[0];
    cur[1] = 8'h58;
    pack();
    req = 3'b011;
    for (int w = 0; w < 5; w++) begin
      wait_write("line", 60, n);
      got[w] = u_din[7:0];
      if (ack[0]) begin
        p0++;
        if (p0 < 4) cur[0] = msg[p0];
        else req = req & 3'b110;
      end
      if (ack[1]) req = req & 3'b101;
      pack();
    end
    for (int w = 0; w < 5; w++) chk("line_order", got[w], exp_ll[w]);
    req = '0;

    // Randomized traffic against the reference model.
    do_reset();
    rr_m = 0;
    lk_m = 1'b0;
    lid_m = 0;
    last_w = -1;
    nw = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (((req >> i) & 1) == 0) begin
          if ($urandom_range(0, 5) == 0) begin
            cur[i] = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            req = req | (3'b001 << i);
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req = req & ~(3'b001 << i);
        end
      end
      pack();
      tx_ready = ($urandom_range(0, 5) != 0);
      cyc();
      if (u_cs) begin
        g = model_pick(req_at_edge, rr_m, lk_m, lid_m);
        chk("rnd_valid", g >= 0, 1);
        if (g >= 0) begin
          chk("rnd_ack", ack, 3'b001 << g);
          chk("rnd_din", u_din, {24'b0, cur[g]});
          chk("rnd_addr", u_addr, 0);
          req = req & ~(3'b001 << g);
          if (LOCK && cur[g] != 8'h0A) begin
            lk_m = 1'b1;
            lid_m = g;
          end else begin
            lk_m = 1'b0;
            rr_m = (g + 1) % NREQ;
          end
        end
        if (last_w >= 0) chk("rnd_spacing", (cycle - last_w) >= MIN_GAP + 3, 1);
        last_w = cycle;
        nw++;
      end else begin
        chk("rnd_ack_idle", ack, 0);
      end
    end
    chk("rnd_write_count", nw > 50, 1);
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
